// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared constants for the vscale memory arbiter: memory access sizes
// (same encodings the core uses) and the bus data-phase owner encoding.
package vscale_mem_arbiter_pkg;

    localparam int MEM_TYPE_WIDTH = 3;

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B  = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H  = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W  = 3'd2;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_D  = 3'd3;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_BU = 3'd4;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_HU = 3'd5;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_WU = 3'd6;

    localparam int ARB_OWNER_WIDTH = 2;

    // Who owns the bus data phase in the current cycle.
    typedef enum logic [ARB_OWNER_WIDTH-1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_IMEM = 2'd1,
        ARB_OWNER_DMEM = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/vscale_mem_arbiter_hold.sv
// Per-master request latch: remembers an accepted address phase that
// could not be put on the bus in the same cycle.
module vscale_arb_hold #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wen,
    input  logic [SIZE_W-1:0] i_size,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wen,
    output logic [SIZE_W-1:0] o_size
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [SIZE_W-1:0] r_size;

    // Valid bit: set on capture, dropped when the held request is granted.
    // Set and clear never coincide because a held master is kept waiting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    // Request payload captured together with the valid bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
            r_wen  <= 1'b0;
            r_size <= '0;
        end else if (i_set) begin
            r_addr <= i_addr;
            r_wen  <= i_wen;
            r_size <= i_size;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_wen   = r_wen;
    assign o_size  = r_size;

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Two-master arbiter (instruction fetch / load-store) in front of one
// pipelined single-ported bus. Address phase in cycle t, data phase in
// t+1. Handshake: a master's request is taken in any cycle where it is
// asserted and that master's wait output is low; the bus takes an address
// whenever it has no data phase pending or that data phase completes
// (bus_ready) in the same cycle; wait stays high until the data phase
// of the master's own transfer completes.
module vscale_mem_arbiter
    import vscale_mem_arbiter_pkg::*;
#(
    parameter int XPR_LEN      = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_imem_req,
    input  logic [XPR_LEN-1:0]        i_imem_addr,
    output logic                      o_imem_wait,
    output logic [XPR_LEN-1:0]        o_imem_rdata,
    output logic                      o_imem_badmem_e,
    input  logic                      i_dmem_en,
    input  logic                      i_dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] i_dmem_size,
    input  logic [XPR_LEN-1:0]        i_dmem_addr,
    input  logic [XPR_LEN-1:0]        i_dmem_wdata_delayed,
    output logic                      o_dmem_wait,
    output logic [XPR_LEN-1:0]        o_dmem_rdata,
    output logic                      o_dmem_badmem_e,
    output logic                      o_bus_valid,
    output logic [XPR_LEN-1:0]        o_bus_addr,
    output logic                      o_bus_wen,
    output logic [MEM_TYPE_WIDTH-1:0] o_bus_size,
    output logic [XPR_LEN-1:0]        o_bus_wdata,
    input  logic [XPR_LEN-1:0]        i_bus_rdata,
    input  logic                      i_bus_ready,
    input  logic                      i_bus_error,
    output arb_owner_e                o_dbg_dp_owner
);

    localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_owner_e                r_dp_owner;
    logic                      r_dp_wen;
    logic                      r_i_dp;
    logic                      r_d_dp;
    logic [STREAK_W-1:0]       r_d_streak;

    logic                      w_i_hold_valid, w_d_hold_valid;
    logic [XPR_LEN-1:0]        w_i_hold_addr, w_d_hold_addr;
    logic                      w_i_hold_wen, w_d_hold_wen;
    logic [MEM_TYPE_WIDTH-1:0] w_i_hold_size, w_d_hold_size;

    logic w_i_served, w_d_served;
    logic w_i_wait, w_d_wait;
    logic w_i_accept, w_d_accept;
    logic w_i_cand, w_d_cand;
    logic w_bus_free;
    logic w_grant_i, w_grant_d;

    arb_owner_e                w_dp_owner_next;
    logic                      w_dp_wen_next;
    logic [STREAK_W-1:0]       w_d_streak_next;
    logic [XPR_LEN-1:0]        w_bus_addr;
    logic                      w_bus_wen;
    logic [MEM_TYPE_WIDTH-1:0] w_bus_size;

    // Completion, acceptance and candidate terms for both masters.
    always_comb begin
        w_i_served = (r_dp_owner == ARB_OWNER_IMEM) && i_bus_ready;
        w_d_served = (r_dp_owner == ARB_OWNER_DMEM) && i_bus_ready;
        w_i_wait   = r_i_dp && !w_i_served;
        w_d_wait   = r_d_dp && !w_d_served;
        w_i_accept = i_imem_req && !w_i_wait;
        w_d_accept = i_dmem_en && !w_d_wait;
        w_i_cand   = w_i_hold_valid || w_i_accept;
        w_d_cand   = w_d_hold_valid || w_d_accept;
        w_bus_free = (r_dp_owner == ARB_OWNER_NONE) || i_bus_ready;
    end

    // Grant: dmem first, except imem wins once dmem has used up its streak.
    always_comb begin
        w_grant_d = w_bus_free && w_d_cand && !(w_i_cand && (r_d_streak == STREAK_MAX));
        w_grant_i = w_bus_free && w_i_cand && !w_grant_d;
    end

    // Address-phase mux and next data-phase owner; a held request beats the live one.
    always_comb begin
        w_bus_addr      = '0;
        w_bus_wen       = 1'b0;
        w_bus_size      = '0;
        w_dp_owner_next = r_dp_owner;
        w_dp_wen_next   = r_dp_wen;
        if (w_grant_d) begin
            w_bus_addr = w_d_hold_valid ? w_d_hold_addr : i_dmem_addr;
            w_bus_wen  = w_d_hold_valid ? w_d_hold_wen  : i_dmem_wen;
            w_bus_size = w_d_hold_valid ? w_d_hold_size : i_dmem_size;
        end else if (w_grant_i) begin
            w_bus_addr = w_i_hold_valid ? w_i_hold_addr : i_imem_addr;
            w_bus_wen  = w_i_hold_valid ? w_i_hold_wen  : 1'b0;
            w_bus_size = w_i_hold_valid ? w_i_hold_size : MEM_TYPE_W;
        end
        if (w_bus_free) begin
            w_dp_owner_next = w_grant_d ? ARB_OWNER_DMEM :
                              w_grant_i ? ARB_OWNER_IMEM : ARB_OWNER_NONE;
            w_dp_wen_next   = w_bus_wen;
        end
    end

    // Streak counter: counts dmem wins while imem is waiting, saturating.
    always_comb begin
        w_d_streak_next = r_d_streak;
        if (w_grant_i || !w_i_cand) begin
            w_d_streak_next = '0;
        end else if (w_grant_d && (r_d_streak != STREAK_MAX)) begin
            w_d_streak_next = r_d_streak + 1'b1;
        end
    end

    // Arbiter state registers; reset abandons any in-flight transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dp_owner <= ARB_OWNER_NONE;
            r_dp_wen   <= 1'b0;
            r_i_dp     <= 1'b0;
            r_d_dp     <= 1'b0;
            r_d_streak <= '0;
        end else begin
            r_dp_owner <= w_dp_owner_next;
            r_dp_wen   <= w_dp_wen_next;
            r_i_dp     <= w_i_wait || i_imem_req;
            r_d_dp     <= w_d_wait || i_dmem_en;
            r_d_streak <= w_d_streak_next;
        end
    end

    vscale_arb_hold #(.ADDR_W(XPR_LEN), .SIZE_W(MEM_TYPE_WIDTH)) u_i_hold (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_set   (w_i_accept && !w_grant_i),
        .i_clr   (w_grant_i),
        .i_addr  (i_imem_addr),
        .i_wen   (1'b0),
        .i_size  (MEM_TYPE_W),
        .o_valid (w_i_hold_valid),
        .o_addr  (w_i_hold_addr),
        .o_wen   (w_i_hold_wen),
        .o_size  (w_i_hold_size)
    );

    vscale_arb_hold #(.ADDR_W(XPR_LEN), .SIZE_W(MEM_TYPE_WIDTH)) u_d_hold (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_set   (w_d_accept && !w_grant_d),
        .i_clr   (w_grant_d),
        .i_addr  (i_dmem_addr),
        .i_wen   (i_dmem_wen),
        .i_size  (i_dmem_size),
        .o_valid (w_d_hold_valid),
        .o_addr  (w_d_hold_addr),
        .o_wen   (w_d_hold_wen),
        .o_size  (w_d_hold_size)
    );

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        o_imem_wait     = !i_reset && w_i_wait;
        o_dmem_wait     = !i_reset && w_d_wait;
        o_imem_rdata    = i_reset ? '0 : i_bus_rdata;
        o_dmem_rdata    = i_reset ? '0 : i_bus_rdata;
        o_imem_badmem_e = !i_reset && i_bus_error && w_i_served;
        o_dmem_badmem_e = !i_reset && i_bus_error && w_d_served;
        o_bus_valid     = !i_reset && (w_grant_i || w_grant_d);
        o_bus_addr      = i_reset ? '0 : w_bus_addr;
        o_bus_wen       = !i_reset && w_bus_wen;
        o_bus_size      = i_reset ? '0 : w_bus_size;
        o_bus_wdata     = (!i_reset && (r_dp_owner == ARB_OWNER_DMEM) && r_dp_wen)
                          ? i_dmem_wdata_delayed : '0;
        o_dbg_dp_owner  = i_reset ? ARB_OWNER_NONE : r_dp_owner;
    end

endmodule
